// File: rtl/decoder_riscv_pipe.sv
// -----------------------------------------------------------------------------
// decoder_riscv_pipe
//   One-stage RV32I (optionally RV32M) instruction decoder with a valid/ready
//   skid-free output register. Each accepted instruction is decoded
//   combinationally and registered together with a copy of the raw word.
//   A saturating counter tracks how many illegal words were handed off.
//
//   Encodings shared with the rest of the core:
//     a_sel    : 0 RS1, 1 CURRENT_PC, 2 ZERO
//     b_sel    : 0 RS2, 1 IMM_I, 2 IMM_S, 3 IMM_U, 4 INCR
//     alu_op   : 0 ADD 1 SUB 2 XOR 3 OR 4 AND 5 SLL 6 SRL 7 SRA 8 SLT 9 SLTU
//                10 EQ 11 NE 12 LTS 13 GES 14 LTU 15 GEU
//     csr_op   : funct3 of the CSR instruction (default 1 = RW)
//     wb_sel   : 0 EX_RESULT, 1 LSU_DATA, 2 CSR_DATA
//     mem_size : 0 B, 1 H, 2 W, 4 BU, 5 HU
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   instr_i, in_valid_i      incoming instruction and its valid
//   in_ready_o               decoder can take instr_i this cycle
//   flush_i                  drop held and incoming instruction
//   out_ready_i, out_valid_o downstream handshake
//   a_sel_o .. mret_o        registered decode fields and flags
//   instr_o                  registered copy of the decoded word
//   illegal_cnt_o            saturating count of illegal handoffs
// -----------------------------------------------------------------------------
module decoder_riscv_pipe #(
  parameter int unsigned M_EXT_EN = 0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [31:0]      instr_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             flush_i,
  input  logic             out_ready_i,
  output logic             out_valid_o,
  output logic [1:0]       a_sel_o,
  output logic [2:0]       b_sel_o,
  output logic [4:0]       alu_op_o,
  output logic [2:0]       csr_op_o,
  output logic             csr_we_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [2:0]       mem_size_o,
  output logic             gpr_we_o,
  output logic [1:0]       wb_sel_o,
  output logic             mdu_en_o,
  output logic [2:0]       mdu_op_o,
  output logic             illegal_instr_o,
  output logic             branch_o,
  output logic             jal_o,
  output logic             jalr_o,
  output logic             mret_o,
  output logic [31:0]      instr_o,
  output logic [CNT_W-1:0] illegal_cnt_o
);

  localparam logic [1:0] A_RS1        = 2'd0;
  localparam logic [1:0] A_CURRENT_PC = 2'd1;
  localparam logic [1:0] A_ZERO       = 2'd2;

  localparam logic [2:0] B_RS2   = 3'd0;
  localparam logic [2:0] B_IMM_I = 3'd1;
  localparam logic [2:0] B_IMM_S = 3'd2;
  localparam logic [2:0] B_IMM_U = 3'd3;
  localparam logic [2:0] B_INCR  = 3'd4;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_XOR  = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_AND  = 5'd4;
  localparam logic [4:0] ALU_SLL  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_SLT  = 5'd8;
  localparam logic [4:0] ALU_SLTU = 5'd9;
  localparam logic [4:0] ALU_EQ   = 5'd10;
  localparam logic [4:0] ALU_NE   = 5'd11;
  localparam logic [4:0] ALU_LTS  = 5'd12;
  localparam logic [4:0] ALU_GES  = 5'd13;
  localparam logic [4:0] ALU_LTU  = 5'd14;
  localparam logic [4:0] ALU_GEU  = 5'd15;

  localparam logic [2:0] CSR_RW = 3'd1;

  localparam logic [1:0] WB_EX_RESULT = 2'd0;
  localparam logic [1:0] WB_LSU_DATA  = 2'd1;
  localparam logic [1:0] WB_CSR_DATA  = 2'd2;

  localparam logic [2:0] SZ_B  = 3'd0;
  localparam logic [2:0] SZ_H  = 3'd1;
  localparam logic [2:0] SZ_W  = 3'd2;
  localparam logic [2:0] SZ_BU = 3'd4;
  localparam logic [2:0] SZ_HU = 3'd5;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [31:0]      MRET_WORD = 32'h3020_0073;
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  // Register-register / register-immediate ALU op selected by funct3 alone.
  function automatic logic [4:0] alu_base(input logic [2:0] f3);
    logic [4:0] op;
    case (f3)
      3'd0:    op = ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = ALU_SRL;
      3'd6:    op = ALU_OR;
      3'd7:    op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  logic [6:0]       opcode_s;
  logic [2:0]       funct3_s;
  logic [6:0]       funct7_s;
  logic [1:0]       a_sel_s;
  logic [2:0]       b_sel_s;
  logic [4:0]       alu_op_s;
  logic [2:0]       csr_op_s;
  logic             csr_we_s;
  logic             mem_req_s;
  logic             mem_we_s;
  logic [2:0]       mem_size_s;
  logic             gpr_we_s;
  logic [1:0]       wb_sel_s;
  logic             mdu_en_s;
  logic             illegal_s;
  logic             branch_s;
  logic             jal_s;
  logic             jalr_s;
  logic             mret_s;
  logic             in_ready_s;
  logic             accept_s;
  logic             handoff_s;

  logic             out_valid_r;
  logic [1:0]       a_sel_r;
  logic [2:0]       b_sel_r;
  logic [4:0]       alu_op_r;
  logic [2:0]       csr_op_r;
  logic             csr_we_r;
  logic             mem_req_r;
  logic             mem_we_r;
  logic [2:0]       mem_size_r;
  logic             gpr_we_r;
  logic [1:0]       wb_sel_r;
  logic             mdu_en_r;
  logic [2:0]       mdu_op_r;
  logic             illegal_r;
  logic             branch_r;
  logic             jal_r;
  logic             jalr_r;
  logic             mret_r;
  logic [31:0]      instr_r;
  logic [CNT_W-1:0] illegal_cnt_r;

  assign opcode_s = instr_i[6:0];
  assign funct3_s = instr_i[14:12];
  assign funct7_s = instr_i[31:25];

  // Combinational decode of instr_i; side-effect flags are raw here and are
  // gated with the illegal flag before being registered.
  always_comb begin
    a_sel_s    = A_RS1;
    b_sel_s    = B_IMM_I;
    alu_op_s   = ALU_ADD;
    csr_op_s   = CSR_RW;
    csr_we_s   = 1'b0;
    mem_req_s  = 1'b0;
    mem_we_s   = 1'b0;
    mem_size_s = SZ_W;
    gpr_we_s   = 1'b1;
    wb_sel_s   = WB_EX_RESULT;
    mdu_en_s   = 1'b0;
    illegal_s  = 1'b0;
    branch_s   = 1'b0;
    jal_s      = 1'b0;
    jalr_s     = 1'b0;
    mret_s     = 1'b0;
    case (opcode_s)
      OPC_OP: begin
        b_sel_s = B_RS2;
        case (funct7_s)
          7'h00: alu_op_s = alu_base(funct3_s);
          7'h20: begin
            if (funct3_s == 3'd0) begin
              alu_op_s = ALU_SUB;
            end else if (funct3_s == 3'd5) begin
              alu_op_s = ALU_SRA;
            end else begin
              illegal_s = 1'b1;
            end
          end
          7'h01: begin
            if (M_EXT_EN != 32'd0) begin
              mdu_en_s = 1'b1;
            end else begin
              illegal_s = 1'b1;
            end
          end
          default: illegal_s = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        // Shift-immediates reuse funct7 as an encoding field.
        case (funct3_s)
          3'd1: begin
            alu_op_s  = ALU_SLL;
            illegal_s = (funct7_s != 7'h00);
          end
          3'd5: begin
            if (funct7_s == 7'h20) begin
              alu_op_s = ALU_SRA;
            end else begin
              alu_op_s  = ALU_SRL;
              illegal_s = (funct7_s != 7'h00);
            end
          end
          default: alu_op_s = alu_base(funct3_s);
        endcase
      end
      OPC_LOAD: begin
        mem_req_s = 1'b1;
        wb_sel_s  = WB_LSU_DATA;
        case (funct3_s)
          3'd0:    mem_size_s = SZ_B;
          3'd1:    mem_size_s = SZ_H;
          3'd2:    mem_size_s = SZ_W;
          3'd4:    mem_size_s = SZ_BU;
          3'd5:    mem_size_s = SZ_HU;
          default: illegal_s  = 1'b1;
        endcase
      end
      OPC_STORE: begin
        mem_req_s = 1'b1;
        mem_we_s  = 1'b1;
        gpr_we_s  = 1'b0;
        b_sel_s   = B_IMM_S;
        case (funct3_s)
          3'd0:    mem_size_s = SZ_B;
          3'd1:    mem_size_s = SZ_H;
          3'd2:    mem_size_s = SZ_W;
          default: illegal_s  = 1'b1;
        endcase
      end
      OPC_BRANCH: begin
        branch_s = 1'b1;
        gpr_we_s = 1'b0;
        b_sel_s  = B_RS2;
        case (funct3_s)
          3'd0:    alu_op_s  = ALU_EQ;
          3'd1:    alu_op_s  = ALU_NE;
          3'd4:    alu_op_s  = ALU_LTS;
          3'd5:    alu_op_s  = ALU_GES;
          3'd6:    alu_op_s  = ALU_LTU;
          3'd7:    alu_op_s  = ALU_GEU;
          default: illegal_s = 1'b1;
        endcase
      end
      OPC_JAL: begin
        jal_s   = 1'b1;
        a_sel_s = A_CURRENT_PC;
        b_sel_s = B_INCR;
      end
      OPC_JALR: begin
        jalr_s    = 1'b1;
        a_sel_s   = A_CURRENT_PC;
        b_sel_s   = B_INCR;
        illegal_s = (funct3_s != 3'd0);
      end
      OPC_LUI: begin
        a_sel_s = A_ZERO;
        b_sel_s = B_IMM_U;
      end
      OPC_AUIPC: begin
        a_sel_s = A_CURRENT_PC;
        b_sel_s = B_IMM_U;
      end
      OPC_MISC_MEM: begin
        gpr_we_s  = 1'b0;
        illegal_s = (funct3_s != 3'd0);
      end
      OPC_SYSTEM: begin
        case (funct3_s)
          3'd0: begin
            // Only MRET is supported among the privileged funct3=0 words.
            if (instr_i == MRET_WORD) begin
              mret_s   = 1'b1;
              gpr_we_s = 1'b0;
            end else begin
              illegal_s = 1'b1;
            end
          end
          3'd4: illegal_s = 1'b1;
          default: begin
            csr_we_s = 1'b1;
            wb_sel_s = WB_CSR_DATA;
            csr_op_s = funct3_s;
          end
        endcase
      end
      default: illegal_s = 1'b1;
    endcase
  end

  assign in_ready_s = ~out_valid_r | out_ready_i;
  assign accept_s   = in_valid_i & in_ready_s & ~flush_i;
  assign handoff_s  = out_valid_r & out_ready_i & ~flush_i;

  // Output valid: flush wins, then a new accept, then a completed handoff.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_r <= 1'b0;
    end else if (flush_i) begin
      out_valid_r <= 1'b0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
    end else if (out_ready_i) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // Decoded word register; loads only on accept so a stall holds every field.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_sel_r    <= A_RS1;
      b_sel_r    <= B_IMM_I;
      alu_op_r   <= ALU_ADD;
      csr_op_r   <= CSR_RW;
      csr_we_r   <= 1'b0;
      mem_req_r  <= 1'b0;
      mem_we_r   <= 1'b0;
      mem_size_r <= SZ_W;
      gpr_we_r   <= 1'b0;
      wb_sel_r   <= WB_EX_RESULT;
      mdu_en_r   <= 1'b0;
      mdu_op_r   <= 3'd0;
      illegal_r  <= 1'b0;
      branch_r   <= 1'b0;
      jal_r      <= 1'b0;
      jalr_r     <= 1'b0;
      mret_r     <= 1'b0;
      instr_r    <= 32'd0;
    end else if (accept_s) begin
      a_sel_r    <= a_sel_s;
      b_sel_r    <= b_sel_s;
      alu_op_r   <= alu_op_s;
      csr_op_r   <= csr_op_s;
      csr_we_r   <= csr_we_s  & ~illegal_s;
      mem_req_r  <= mem_req_s & ~illegal_s;
      mem_we_r   <= mem_we_s  & ~illegal_s;
      mem_size_r <= mem_size_s;
      gpr_we_r   <= gpr_we_s  & ~illegal_s;
      wb_sel_r   <= wb_sel_s;
      mdu_en_r   <= mdu_en_s  & ~illegal_s;
      mdu_op_r   <= funct3_s;
      illegal_r  <= illegal_s;
      branch_r   <= branch_s  & ~illegal_s;
      jal_r      <= jal_s     & ~illegal_s;
      jalr_r     <= jalr_s    & ~illegal_s;
      mret_r     <= mret_s    & ~illegal_s;
      instr_r    <= instr_i;
    end else begin
      instr_r    <= instr_r;
    end
  end

  // Saturating count of illegal words actually delivered downstream.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      illegal_cnt_r <= {CNT_W{1'b0}};
    end else if (handoff_s && illegal_r && (illegal_cnt_r != CNT_MAX)) begin
      illegal_cnt_r <= illegal_cnt_r + CNT_W'(1'b1);
    end else begin
      illegal_cnt_r <= illegal_cnt_r;
    end
  end

  assign in_ready_o      = in_ready_s;
  assign out_valid_o     = out_valid_r;
  assign a_sel_o         = a_sel_r;
  assign b_sel_o         = b_sel_r;
  assign alu_op_o        = alu_op_r;
  assign csr_op_o        = csr_op_r;
  assign csr_we_o        = csr_we_r;
  assign mem_req_o       = mem_req_r;
  assign mem_we_o        = mem_we_r;
  assign mem_size_o      = mem_size_r;
  assign gpr_we_o        = gpr_we_r;
  assign wb_sel_o        = wb_sel_r;
  assign mdu_en_o        = mdu_en_r;
  assign mdu_op_o        = mdu_op_r;
  assign illegal_instr_o = illegal_r;
  assign branch_o        = branch_r;
  assign jal_o           = jal_r;
  assign jalr_o          = jalr_r;
  assign mret_o          = mret_r;
  assign instr_o         = instr_r;
  assign illegal_cnt_o   = illegal_cnt_r;

endmodule
